// File: rtl/pp_buffer_if.sv
// Byte-stream port bundle for the ping-pong buffer.
// Handshake: the producer presents `in` with `in_vaild` for a single cycle
// and the word is taken at that edge if a bank is free (otherwise dropped).
// The consumer raises `busy` to stall. `out_vaild` marks a fresh `out` word
// for exactly one cycle, and `out` holds its value between words.
interface pp_buffer_if #(
  parameter int WIDTH = 8
);
  logic             in_vaild;
  logic             busy;
  logic [WIDTH-1:0] in;
  logic             out_vaild;
  logic [WIDTH-1:0] out;

  // Producer/consumer side: drives write data and back-pressure.
  modport master (
    output in_vaild,
    output busy,
    output in,
    input  out_vaild,
    input  out
  );

  // Buffer side.
  modport slave (
    input  in_vaild,
    input  busy,
    input  in,
    output out_vaild,
    output out
  );
endinterface

// File: rtl/pp_buffer.sv
// Ping-pong byte stream buffer. The writer fills one bank while the reader
// drains the other. A bank belongs to the writer while its full flag is
// clear and to the reader while it is set. A one-cycle look-ahead on the
// reader's last word keeps the stream running at one word per cycle.
module pp_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  pp_buffer_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [AW-1:0] idx_t;
  localparam idx_t LAST = idx_t'(DEPTH - 1);

  // Storage is not reset; the full flags decide what is meaningful.
  logic [WIDTH-1:0] mem [2][DEPTH];

  logic [1:0] full;
  logic       wr_sel;
  idx_t       wr_cnt;
  logic       rd_sel;
  idx_t       rd_cnt;

  logic       wr_fire;
  logic       wr_last;
  logic       rd_fire;
  logic       rd_last;
  logic       other_free;
  logic       wr_swap;
  logic [1:0] full_next;

  // Decode the write/read events and the writer's bank-swap decision.
  always_comb begin
    wr_fire    = bus.in_vaild && !full[wr_sel];
    wr_last    = wr_fire && (wr_cnt == LAST);
    rd_fire    = full[rd_sel] && !bus.busy;
    rd_last    = rd_fire && (rd_cnt == LAST);
    // The other bank counts as free if it is empty now, or if the reader is
    // handing out its final word on this very edge.
    other_free = !full[~wr_sel] || (rd_last && (rd_sel == ~wr_sel));
    // Swap once the current bank is full (or fills on this edge).
    wr_swap    = (full[wr_sel] || wr_last) && other_free;
    full_next  = full;
    if (wr_last) full_next[wr_sel] = 1'b1;
    if (rd_last) full_next[rd_sel] = 1'b0;
  end

  // Write accepted words into the writer's bank.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_sel][wr_cnt] <= bus.in;
  end

  // Writer pointer, bank flags and bank selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      wr_cnt <= '0;
    end else begin
      full <= full_next;
      if (wr_fire) wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
      if (wr_swap) wr_sel <= ~wr_sel;
    end
  end

  // Reader pointer; it toggles banks after the last word of a bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel <= 1'b0;
      rd_cnt <= '0;
    end else if (rd_fire) begin
      rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
      if (rd_last) rd_sel <= ~rd_sel;
    end
  end

  // Registered output: one strobe per issued word, data held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_vaild <= 1'b0;
      bus.out       <= '0;
    end else begin
      bus.out_vaild <= rd_fire;
      if (rd_fire) bus.out <= mem[rd_sel][rd_cnt];
    end
  end

endmodule

// File: tb/tb_pp_buffer.sv
// Bench for pp_buffer: cycle model of bank occupancy, expected-word queue,
// monitor on the falling edge, directed scenarios.
module tb_pp_buffer;

  localparam int W = 8;
  localparam int D = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pp_buffer_if #(.WIDTH(W)) bus ();

  pp_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           n_out    = 0;
  int           m_nfull  = 0;
  int           m_wc     = 0;
  int           m_rc     = 0;
  int           m_drops  = 0;
  bit           m_vaild  = 1'b0;
  bit           m_rd;
  bit           m_wr;
  logic [W-1:0] m_last_out = '0;
  logic [W-1:0] exp_word;
  int           base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Occupancy model: a word is accepted unless two complete banks are held;
  // a word is issued whenever a complete bank exists and busy is low.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_nfull = 0;
      m_wc    = 0;
      m_rc    = 0;
      m_vaild = 1'b0;
      exp_q.delete();
    end else begin
      m_rd = (m_nfull > 0) && !bus.busy;
      m_wr = bus.in_vaild && (m_nfull < 2);
      if (bus.in_vaild && !m_wr) m_drops++;
      if (m_wr) begin
        exp_q.push_back(bus.in);
        m_wc++;
        if (m_wc == D) begin
          m_wc = 0;
          m_nfull++;
        end
      end
      if (m_rd) begin
        m_rc++;
        if (m_rc == D) begin
          m_rc = 0;
          m_nfull--;
        end
      end
      m_vaild = m_rd;
    end
  end

  // Monitor: strobe timing every cycle, data on strobes, hold otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_last_out = '0;
    end else begin
      check("out_vaild", 32'(bus.out_vaild), 32'(m_vaild));
      if (bus.out_vaild) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("out_extra", 32'(bus.out), 32'hFFFF_FFFF);
        end else begin
          exp_word = exp_q.pop_front();
          check("out_data", 32'(bus.out), 32'(exp_word));
          m_last_out = exp_word;
        end
      end else begin
        check("out_hold", 32'(bus.out), 32'(m_last_out));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit b);
    @(posedge clk);
    #1;
    bus.in_vaild = v;
    bus.in       = d;
    bus.busy     = b;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n        = 1'b0;
    bus.in_vaild = 1'b0;
    bus.busy     = 1'b0;
    bus.in       = '0;

    // Reset held: writes have no effect on the outputs.
    for (int i = 0; i < 5; i++) cyc(1'b1, W'($urandom_range(0, 255)), 1'b0);
    @(negedge clk);
    check("rst_vaild", 32'(bus.out_vaild), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    @(posedge clk);
    #1;
    bus.in_vaild = 1'b0;
    rst_n        = 1'b1;

    // Ramp: 1000 words back-to-back, no back-pressure.
    base = n_out;
    for (int i = 1; i <= 1000; i++) cyc(1'b1, W'(i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    wait_drain();
    check("ramp_count", 32'(n_out - base), 32'd1000);

    // Partial bank stays invisible until it completes.
    base = n_out;
    for (int i = 0; i < 5; i++) cyc(1'b1, W'($urandom_range(0, 255)), 1'b0);
    repeat (10) cyc(1'b0, '0, 1'b0);
    check("partial_none", 32'(n_out - base), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, W'($urandom_range(0, 255)), 1'b0);
    cyc(1'b0, '0, 1'b0);
    wait_drain();
    check("partial_count", 32'(n_out - base), 32'd8);

    // Back-pressure for three edges right after word 3 is issued.
    base = n_out;
    for (int i = 0; i < 8; i++) cyc(1'b1, W'(8'h40 + i), 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1);
    @(negedge clk);
    check("bp_vaild", 32'(bus.out_vaild), 32'd0);
    check("bp_hold", 32'(bus.out), 32'h42);
    cyc(1'b0, '0, 1'b0);
    wait_drain();
    check("bp_count", 32'(n_out - base), 32'd8);

    // Overflow: consumer stalled, 20 writes, only two banks' worth survive.
    base = n_out;
    for (int i = 1; i <= 20; i++) cyc(1'b1, W'(8'h80 + i), 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b1);
    check("ovf_none", 32'(n_out - base), 32'd0);
    cyc(1'b0, '0, 1'b0);
    wait_drain();
    check("ovf_count", 32'(n_out - base), 32'd16);

    // Reset mid-stream, asserted between clock edges.
    for (int i = 1; i <= 11; i++) cyc(1'b1, W'(8'hC0 + i), 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_vaild", 32'(bus.out_vaild), 32'd1);
    #1;
    rst_n        = 1'b0;
    bus.in_vaild = 1'b0;
    #1;
    check("async_vaild", 32'(bus.out_vaild), 32'd0);
    check("async_out", 32'(bus.out), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base  = n_out;
    for (int i = 1; i <= 8; i++) cyc(1'b1, W'(8'hE0 + i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    wait_drain();
    check("rst_count", 32'(n_out - base), 32'd8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
